// File: rtl/mtsp_alu_wb_sched_if.sv
// Issue/writeback bundle between the instruction sequencer and the ALU writeback scheduler.
// The master modport is the sequencer side; the slave modport is the scheduler side.
interface mtsp_alu_wb_sched_if #(
  parameter int TAG_W = 5
);
  logic             ISSUE_VALID;
  logic [2:0]       ISSUE_LAT;
  logic             ISSUE_WEN;
  logic [TAG_W-1:0] ISSUE_DST;
  logic             ISSUE_USEA;
  logic             ISSUE_USEB;
  logic [TAG_W-1:0] ISSUE_SRCA;
  logic [TAG_W-1:0] ISSUE_SRCB;
  logic             FLUSH;
  logic             ISSUE_READY;
  logic             ISSUE_ERR;
  logic             WB_VALID;
  logic [TAG_W-1:0] WB_TAG;
  logic             WMASK;
  logic             BUSY;

  modport master (
    output ISSUE_VALID, ISSUE_LAT, ISSUE_WEN, ISSUE_DST,
           ISSUE_USEA, ISSUE_USEB, ISSUE_SRCA, ISSUE_SRCB, FLUSH,
    input  ISSUE_READY, ISSUE_ERR, WB_VALID, WB_TAG, WMASK, BUSY
  );

  modport slave (
    input  ISSUE_VALID, ISSUE_LAT, ISSUE_WEN, ISSUE_DST,
           ISSUE_USEA, ISSUE_USEB, ISSUE_SRCA, ISSUE_SRCB, FLUSH,
    output ISSUE_READY, ISSUE_ERR, WB_VALID, WB_TAG, WMASK, BUSY
  );
endinterface

// File: rtl/mtsp_alu_wb_sched.sv
// ALU writeback issue scheduler: books one writeback slot per future cycle, keeps a
// RAW/WAW register scoreboard and emits the writeback valid/tag aligned with DEST.
module mtsp_alu_wb_sched #(
  parameter int MAX_LAT = 6,
  parameter int TAG_W   = 5
) (
  input  logic                        CLK,
  input  logic                        nRST,
  mtsp_alu_wb_sched_if.slave          bus
);

  localparam int         NREG    = 1 << TAG_W;
  localparam logic [2:0] LAT_MAX = 3'(MAX_LAT);

  logic [MAX_LAT-1:0] r_slot;
  logic [MAX_LAT-1:0] r_wen;
  logic [TAG_W-1:0]   r_tag [MAX_LAT];
  logic [NREG-1:0]    r_pend;
  logic               r_err;

  logic               w_legal;
  logic [7:0]         w_slotX;
  logic               w_structOk;
  logic               w_hazOk;
  logic               w_ready;
  logic               w_grant;
  logic [2:0]         w_idx;
  logic               w_wbRaw;
  logic               w_wbValid;
  logic [MAX_LAT-1:0] w_slotNext;
  logic [MAX_LAT-1:0] w_wenNext;
  logic [TAG_W-1:0]   w_tagNext [MAX_LAT];
  logic [NREG-1:0]    w_pendNext;

  // slot[L] holds the booking for cycle now+L; at L==MAX_LAT the zero extension is always free.
  assign w_slotX    = 8'(r_slot);
  assign w_legal    = (bus.ISSUE_LAT != 3'd0) && (bus.ISSUE_LAT <= LAT_MAX);
  assign w_structOk = ~w_slotX[bus.ISSUE_LAT];
  assign w_hazOk    = ~((bus.ISSUE_USEA & r_pend[bus.ISSUE_SRCA]) |
                        (bus.ISSUE_USEB & r_pend[bus.ISSUE_SRCB]) |
                        (bus.ISSUE_WEN  & r_pend[bus.ISSUE_DST]));
  assign w_ready    = ~bus.FLUSH & w_legal & w_structOk & w_hazOk;
  assign w_grant    = bus.ISSUE_VALID & w_ready;
  assign w_idx      = bus.ISSUE_LAT - 3'd1;

  assign w_wbRaw    = r_slot[0] & r_wen[0];
  assign w_wbValid  = w_wbRaw & ~bus.FLUSH;

  assign bus.ISSUE_READY = w_ready;
  assign bus.ISSUE_ERR   = r_err;
  assign bus.WB_VALID    = w_wbValid;
  assign bus.WB_TAG      = w_wbValid ? r_tag[0] : '0;
  assign bus.WMASK       = ~w_wbValid;
  assign bus.BUSY        = (|r_slot) | (|r_pend);

  // The grant is booked after the shift, so slot L-1 reaches slot 0 exactly L cycles later.
  always_comb begin
    w_slotNext = r_slot >> 1;
    w_wenNext  = r_wen >> 1;
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      w_tagNext[k] = r_tag[k+1];
    end
    w_tagNext[MAX_LAT-1] = '0;
    w_pendNext = r_pend;
    if (w_wbRaw) begin
      w_pendNext[r_tag[0]] = 1'b0;
    end
    if (w_grant) begin
      w_slotNext[w_idx] = 1'b1;
      w_wenNext[w_idx]  = bus.ISSUE_WEN;
      w_tagNext[w_idx]  = bus.ISSUE_DST;
      if (bus.ISSUE_WEN) begin
        w_pendNext[bus.ISSUE_DST] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_slot <= '0;
      r_wen  <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
      for (int k = 0; k < MAX_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_err <= bus.ISSUE_VALID & ~w_legal & ~bus.FLUSH;
      if (bus.FLUSH) begin
        r_slot <= '0;
        r_wen  <= '0;
        r_pend <= '0;
        for (int k = 0; k < MAX_LAT; k++) begin
          r_tag[k] <= '0;
        end
      end else begin
        r_slot <= w_slotNext;
        r_wen  <= w_wenNext;
        r_pend <= w_pendNext;
        for (int k = 0; k < MAX_LAT; k++) begin
          r_tag[k] <= w_tagNext[k];
        end
      end
    end
  end

endmodule
